window_block_loader: RTL and testbench
======================================

Name: window_block_loader

Overview:
- Parametrised successor to the fixed-size block loader used between the DMA and the convolution layer.
- Fetches either a KxK image window, addressed by origin row/column inside a row-major image, or a linear block of N words.
- Fetches run over a pipelined, fixed-latency memory read port into a flat output register array.
- Feeds the convolution layer's image/filter operands. One read is issued per cycle, with no per-word handshake.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, memory address width
MAX_K, 5, maximum window side; the output array holds MAX_K*MAX_K words
MEM_LAT, 1, fixed read latency in cycles (>=1) from mem_en to mem_rdata valid

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = window fetch, 1 = linear block fetch
base_addr  in  ADDR_W  image/block base address
img_width  in  ADDR_W  image row length in words
img_height  in  ADDR_W  image row count (used only with PAD_EN)
org_row  in  ADDR_W  window origin row, two's complement
org_col  in  ADDR_W  window origin column, two's complement
k_size  in  ADDR_W  window side, mode 0
lin_size  in  ADDR_W  word count, mode 1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse; win_out is complete and stable
mem_en  out  1  read strobe
mem_addr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en
win_out  out  MAX_K*MAX_K*DATA_W  slot e is bits [e*DATA_W +: DATA_W]

Behaviour:
- Reset (async, active-low): state IDLE; busy=0, done=0, mem_en=0, mem_addr=0, win_out all zero; return-valid pipeline cleared.
- Reset mid-fetch: abort immediately. Returns still in flight are discarded and never written.
- Inputs are latched on an accepted start. Later changes to inputs do not affect the running fetch.
- Word count N:
  - mode 0: N = k*k, where k = min(k_size, MAX_K).
  - mode 1: N = min(lin_size, MAX_K*MAX_K).
- On accept, every win_out slot e >= N is cleared to 0. Slots below N are overwritten as data returns.
- States:
  - IDLE: on start, go to ISSUE, or straight to DRAIN if N=0.
  - ISSUE: one element per cycle, e = 0..N-1 in order. After the last element, go to DRAIN.
  - DRAIN: wait until the return pipeline is empty, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Addressing, element e, all arithmetic modulo 2^ADDR_W:
  - mode 1: addr = base_addr + e.
  - mode 0: i = e / k, j = e mod k; addr = base_addr + (org_row+i)*img_width + (org_col+j).
- Return path: a MEM_LAT-deep shift register carries {valid, slot, pad}. When an entry emerges, its slot is written with mem_rdata, or with 0 if pad is set.
- Latency: with start accepted in cycle 0, issues occur in cycles 1..N and done is high in cycle N+MEM_LAT+1. With N=0, done is high in cycle 2.
- start while busy or during DONE is ignored. No queuing.
- mem_en is never high in IDLE, DRAIN or DONE.

Optional Feature:
PAD_EN
- Defined: in mode 0, org_row+i and org_col+j are treated as signed. A coordinate outside [0,img_height) or [0,img_width) is a pad element:
  - mem_en stays 0 for that cycle;
  - mem_addr holds its previous value;
  - a pad entry enters the return pipeline, so ordering and latency are unchanged and the slot is written 0.
- Undefined: no bounds check, img_height is ignored, every element issues a read, and addresses wrap modulo 2^ADDR_W.

Test Plan:
- Mode 0, base=500, img_width=10, org=(1,2), k_size=3, MEM_LAT=1, memory word[a]=a -> reads 512,513,514,522,523,524,532,533,534 in cycles 1..9; done in cycle 11; slots 0..8 hold those values; slots 9..24 are 0.
- Mode 1, base=0, lin_size=25 -> 25 consecutive reads 0..24, done in cycle 27. Then lin_size=40 -> clamps to 25 reads.
- k_size=0, and separately lin_size=0 -> no mem_en; done in cycle 2; win_out all zero.
- PAD_EN, img 10x10, org=(-1,-1), k_size=3 -> reads only 500,501,510,511 (elements 4,5,7,8); slots 0,1,2,3,6 are 0; done in cycle 11.
- Assert reset low in cycle 4 of a 25-word fetch, release, restart with lin_size=2 -> no stale slot writes; done in cycle 4 after the new start; slots 0..1 hold the new data.
- start pulsed during ISSUE and again during DONE -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/window_block_loader_if.sv
// window_block_loader_if: pipelined fixed-latency memory read port
//   en    read strobe            (master -> memory)
//   addr  read address           (master -> memory)
//   rdata read data, valid a fixed latency after en (memory -> master)
interface window_block_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    modport master (output en, addr, input rdata);
    modport slave (input en, addr, output rdata);
endinterface

// File: rtl/window_block_loader.sv
// window_block_loader: fetches a KxK image window or a linear block into a flat register array
//   clk, reset (async, active-low)
//   start/mode/base_addr/img_width/img_height/org_row/org_col/k_size/lin_size: request, latched on accept
//   busy, done: status; done pulses once when win_out is complete
//   mem: read port (en/addr out, rdata in, MEM_LAT cycles after en)
//   win_out: slot e at bits [e*DATA_W +: DATA_W]
//   Optional PAD_EN: out-of-image window elements are not read and load as 0
module window_block_loader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MAX_K   = 5,
    parameter int MEM_LAT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             img_width,
    input  logic [ADDR_W-1:0]             img_height,
    input  logic [ADDR_W-1:0]             org_row,
    input  logic [ADDR_W-1:0]             org_col,
    input  logic [ADDR_W-1:0]             k_size,
    input  logic [ADDR_W-1:0]             lin_size,
    output logic                          busy,
    output logic                          done,
    window_block_loader_if.master         mem,
    output logic [MAX_K*MAX_K*DATA_W-1:0] win_out
);
    localparam int NE = MAX_K * MAX_K;
    localparam int SW = NE > 1 ? $clog2(NE) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t            state, state_nx;
    logic              mode_q;
    logic [ADDR_W-1:0] base_q, width_q, row_q, col_q, k_q, n_q, e, i, j, addr_q;
    logic [ADDR_W-1:0] k_in, n_in, r, c;
    logic              accept, issue, pad, drain_ok;
    logic              vld_p  [MEM_LAT];
    logic              pad_p  [MEM_LAT];
    logic [SW-1:0]     slot_p [MEM_LAT];
    logic [DATA_W-1:0] win    [NE];
`ifdef PAD_EN
    logic [ADDR_W-1:0] height_q;
`else
    logic              unused_height;
    assign unused_height = ^img_height;
`endif

    assign k_in   = k_size > ADDR_W'(MAX_K) ? ADDR_W'(MAX_K) : k_size;
    assign n_in   = mode ? (lin_size > ADDR_W'(NE) ? ADDR_W'(NE) : lin_size) : k_in * k_in;
    assign accept = state == IDLE && start;
    assign r      = row_q + i;
    assign c      = col_q + j;

    // The last stage empties on this edge, so only earlier stages must be clear.
    always_comb begin
        drain_ok = 1'b1;
        for (int s = 0; s < MEM_LAT - 1; s++) drain_ok = drain_ok & ~vld_p[s];
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        case (state)
            IDLE:    state_nx = start ? (n_in == '0 ? DRAIN : ISSUE) : IDLE;
            ISSUE:   state_nx = e == n_q - ADDR_W'(1) ? DRAIN : ISSUE;
            DRAIN:   state_nx = drain_ok ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // Address is driven only on a real read; otherwise the last issued one is held.
    always_comb begin
        pad = 1'b0;
`ifdef PAD_EN
        pad = state == ISSUE && !mode_q &&
              (r[ADDR_W-1] || r >= height_q || c[ADDR_W-1] || c >= width_q);
`endif
        issue    = state == ISSUE;
        busy     = issue || state == DRAIN;
        done     = state == DONE;
        mem.en   = issue && !pad;
        mem.addr = mem.en ? (mode_q ? base_q + e : base_q + r * width_q + c) : addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {mode_q, base_q, width_q, row_q, col_q, k_q, n_q, e, i, j, addr_q} <= '0;
`ifdef PAD_EN
            height_q <= '0;
`endif
            for (int s = 0; s < MEM_LAT; s++) begin
                vld_p[s]  <= 1'b0;
                pad_p[s]  <= 1'b0;
                slot_p[s] <= '0;
            end
            for (int s = 0; s < NE; s++) win[s] <= '0;
        end else begin
            addr_q    <= mem.addr;
            vld_p[0]  <= issue;
            pad_p[0]  <= pad;
            slot_p[0] <= e[SW-1:0];
            for (int s = 1; s < MEM_LAT; s++) begin
                vld_p[s]  <= vld_p[s-1];
                pad_p[s]  <= pad_p[s-1];
                slot_p[s] <= slot_p[s-1];
            end
            if (accept) begin
                mode_q  <= mode;
                base_q  <= base_addr;
                width_q <= img_width;
`ifdef PAD_EN
                height_q <= img_height;
`endif
                row_q   <= org_row;
                col_q   <= org_col;
                k_q     <= k_in;
                n_q     <= n_in;
                {e, i, j} <= '0;
            end else if (issue) begin
                e <= e + ADDR_W'(1);
                j <= j == k_q - ADDR_W'(1) ? '0 : j + ADDR_W'(1);
                i <= j == k_q - ADDR_W'(1) ? i + ADDR_W'(1) : i;
            end
            // Accept only happens in IDLE, when the return pipeline is already empty.
            for (int s = 0; s < NE; s++)
                if (accept && ADDR_W'(s) >= n_in) win[s] <= '0;
                else if (vld_p[MEM_LAT-1] && slot_p[MEM_LAT-1] == SW'(s))
                    win[s] <= pad_p[MEM_LAT-1] ? '0 : mem.rdata;
        end
    end

    for (genvar g = 0; g < NE; g++) assign win_out[g*DATA_W +: DATA_W] = win[g];
endmodule

// File: tb/tb_window_block_loader.sv
// tb_window_block_loader: directed self-checking bench for window_block_loader (word[a] = a memory)
module tb_window_block_loader;
    logic        clk = 0, reset = 0, start = 0, mode = 0;
    logic [15:0] base_addr = 0, img_width = 0, img_height = 0, org_row = 0, org_col = 0;
    logic [15:0] k_size = 0, lin_size = 0;
    logic        busy, done;
    logic [399:0] win_out;
    int cyc = 0, t0 = 0, checks = 0, passes = 0, fails = 0;
    int ia[$], ic[$], dc[$], ea[$], ec[$];

    window_block_loader_if #(.ADDR_W(16), .DATA_W(16)) mem ();

    window_block_loader dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
        .img_width(img_width), .img_height(img_height), .org_row(org_row), .org_col(org_col),
        .k_size(k_size), .lin_size(lin_size), .busy(busy), .done(done), .mem(mem),
        .win_out(win_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem.rdata <= mem.en ? mem.addr : 16'hdead;

    always @(negedge clk) begin
        if (mem.en) begin
            ia.push_back(int'(mem.addr));
            ic.push_back(cyc - t0);
        end
        if (done) dc.push_back(cyc - t0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic slot(input string tag, input int e, input int v);
        chk($sformatf("%s slot%0d", tag, e), 32'(win_out[e*16 +: 16]), v);
    endtask

    task automatic go(input logic m, input int b, w, h, r, c, k, l);
        @(negedge clk);
        mode = m; base_addr = 16'(b); img_width = 16'(w); img_height = 16'(h);
        org_row = 16'(r); org_col = 16'(c); k_size = 16'(k); lin_size = 16'(l);
        start = 1; t0 = cyc;
        ia.delete(); ic.delete(); dc.delete(); ea.delete(); ec.delete();
        @(negedge clk);
        start = 0; mode = ~m; base_addr = 16'h7777; org_row = 3; org_col = 3;
        k_size = 1; lin_size = 1; img_width = 1; img_height = 1;
    endtask

    task automatic verify(input string tag, input int done_at);
        chk({tag, " issues"}, ia.size(), ea.size());
        for (int x = 0; x < ea.size() && x < ia.size(); x++) begin
            chk($sformatf("%s addr%0d", tag, x), ia[x], ea[x]);
            chk($sformatf("%s cyc%0d", tag, x), ic[x], ec[x]);
        end
        chk({tag, " dones"}, dc.size(), 1);
        if (dc.size() > 0) chk({tag, " done_cyc"}, dc[0], done_at);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst mem_en", mem.en, 0);
        chk("rst mem_addr", mem.addr, 0);
        chk("rst win", |win_out, 0);
        reset = 1;

        go(1, 0, 0, 0, 0, 0, 0, 25);
        chk("lin25 busy c1", busy, 1);
        for (int x = 0; x < 25; x++) begin ea.push_back(x); ec.push_back(x + 1); end
        repeat (30) @(negedge clk);
        verify("lin25", 27);
        for (int x = 0; x < 25; x += 6) slot("lin25", x, x);

        go(1, 100, 0, 0, 0, 0, 0, 40);
        for (int x = 0; x < 25; x++) begin ea.push_back(100 + x); ec.push_back(x + 1); end
        repeat (30) @(negedge clk);
        verify("lin40", 27);
        slot("lin40", 0, 100);
        slot("lin40", 24, 124);

        go(0, 500, 10, 0, 1, 2, 3, 0);
        for (int x = 0; x < 9; x++) begin ea.push_back(500 + (1 + x / 3) * 10 + 2 + x % 3); ec.push_back(x + 1); end
        repeat (14) @(negedge clk);
        verify("m0", 11);
        for (int x = 0; x < 9; x++) slot("m0", x, ea[x]);
        chk("m0 upper clear", |win_out[399:144], 0);

        go(0, 0, 10, 0, 0, 0, 9, 0);
        for (int x = 0; x < 25; x++) begin ea.push_back((x / 5) * 10 + x % 5); ec.push_back(x + 1); end
        repeat (30) @(negedge clk);
        verify("kclamp", 27);
        slot("kclamp", 24, 44);

        go(0, 500, 10, 10, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        verify("k0", 2);
        chk("k0 win", |win_out, 0);

`ifdef PAD_EN
        go(0, 500, 10, 10, -1, -1, 3, 0);
        ea = '{500, 501, 510, 511};
        ec = '{5, 6, 8, 9};
        repeat (14) @(negedge clk);
        verify("pad", 11);
        slot("pad", 0, 0); slot("pad", 1, 0); slot("pad", 2, 0); slot("pad", 3, 0); slot("pad", 6, 0);
        slot("pad", 4, 500); slot("pad", 5, 501); slot("pad", 7, 510); slot("pad", 8, 511);
`else
        go(0, 500, 10, 10, -1, -1, 3, 0);
        ea = '{489, 490, 491, 499, 500, 501, 509, 510, 511};
        for (int x = 0; x < 9; x++) ec.push_back(x + 1);
        repeat (14) @(negedge clk);
        verify("wrap", 11);
        for (int x = 0; x < 9; x++) slot("wrap", x, ea[x]);
`endif

        go(1, 700, 0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        verify("lin0", 2);
        chk("lin0 win", |win_out, 0);

        go(1, 300, 0, 0, 0, 0, 0, 5);
        for (int x = 0; x < 5; x++) begin ea.push_back(300 + x); ec.push_back(x + 1); end
        @(negedge clk);
        mode = 1; lin_size = 3; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("ign done c7", done, 1);
        chk("ign busy c7", busy, 0);
        mode = 1; lin_size = 3; start = 1;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        verify("ignore", 7);

        go(1, 1000, 0, 0, 0, 0, 0, 25);
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("abort win", |win_out, 0);
        chk("abort busy", busy, 0);
        chk("abort mem_en", mem.en, 0);
        reset = 1;
        go(1, 2000, 0, 0, 0, 0, 0, 2);
        ea = '{2000, 2001};
        ec = '{1, 2};
        repeat (8) @(negedge clk);
        verify("restart", 4);
        slot("restart", 0, 2000);
        slot("restart", 1, 2001);
        chk("restart upper", |win_out[399:32], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
